aes_mix_columns: RTL

//  Round stage directly downstream of the ShiftRows function: applies AES MixColumns to a 128-bit state.

---
 rtl/aes_pkg.sv | 69 ++++++
 rtl/aes_mix_col.sv | 36 +++
 rtl/aes_mix_columns.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: stage state encoding, GF(2^8) multiply helpers and column/byte indexing.
package aes_pkg;

   localparam int          BYTE_W   = 32'd8;
   localparam int          COL_W    = 32'd32;
   localparam logic [7:0]  AES_POLY = 8'h1B;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } mix_state_e;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      xtime = {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
   endfunction

   function automatic logic [7:0] gmul2(input logic [7:0] b);
      gmul2 = xtime(b);
   endfunction

   function automatic logic [7:0] gmul3(input logic [7:0] b);
      gmul3 = xtime(b) ^ b;
   endfunction

   // Inverse coefficients are built from the x2/x4/x8 chain of one operand.
   function automatic logic [7:0] gmul9(input logic [7:0] b);
      gmul9 = xtime(xtime(xtime(b))) ^ b;
   endfunction

   function automatic logic [7:0] gmulb(input logic [7:0] b);
      gmulb = xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
   endfunction

   function automatic logic [7:0] gmuld(input logic [7:0] b);
      gmuld = xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
   endfunction

   function automatic logic [7:0] gmule(input logic [7:0] b);
      gmule = xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
   endfunction

   function automatic logic [7:0] mix_row_fwd(input logic [7:0] a0, input logic [7:0] a1,
                                              input logic [7:0] a2, input logic [7:0] a3);
      mix_row_fwd = gmul2(a0) ^ gmul3(a1) ^ a2 ^ a3;
   endfunction

   function automatic logic [7:0] mix_row_inv(input logic [7:0] a0, input logic [7:0] a1,
                                              input logic [7:0] a2, input logic [7:0] a3);
      mix_row_inv = gmule(a0) ^ gmulb(a1) ^ gmuld(a2) ^ gmul9(a3);
   endfunction

   function automatic logic [7:0] col_byte(input logic [31:0] col, input int unsigned row);
      col_byte = col[row*BYTE_W +: BYTE_W];
   endfunction

   function automatic logic [31:0] get_col(input logic [127:0] blk, input int unsigned c);
      get_col = blk[c*COL_W +: COL_W];
   endfunction

   function automatic logic [127:0] set_col(input logic [127:0] blk, input int unsigned c,
                                            input logic [31:0] col);
      logic [127:0] r;
      r = blk;
      r[c*COL_W +: COL_W] = col;
      set_col = r;
   endfunction

endpackage

// File: rtl/aes_mix_col.sv
// Combinational single-column mixer (MixColumns, plus InvMixColumns when AES_MIX_INV_EN is defined).
module aes_mix_col
   import aes_pkg::*;
(
   input  logic [31:0] col,
`ifdef AES_MIX_INV_EN
   input  logic        inv,
`endif
   output logic [31:0] mixed
);

   logic [7:0] b0_s, b1_s, b2_s, b3_s;

   assign b0_s = col_byte(col, 32'd0);
   assign b1_s = col_byte(col, 32'd1);
   assign b2_s = col_byte(col, 32'd2);
   assign b3_s = col_byte(col, 32'd3);

   // Each output row uses the same coefficient set rotated by its row index.
   always_comb begin
      mixed = 32'h0;
`ifdef AES_MIX_INV_EN
      if (inv) begin
         mixed = {mix_row_inv(b3_s, b0_s, b1_s, b2_s), mix_row_inv(b2_s, b3_s, b0_s, b1_s),
                  mix_row_inv(b1_s, b2_s, b3_s, b0_s), mix_row_inv(b0_s, b1_s, b2_s, b3_s)};
      end else begin
         mixed = {mix_row_fwd(b3_s, b0_s, b1_s, b2_s), mix_row_fwd(b2_s, b3_s, b0_s, b1_s),
                  mix_row_fwd(b1_s, b2_s, b3_s, b0_s), mix_row_fwd(b0_s, b1_s, b2_s, b3_s)};
      end
`else
      mixed = {mix_row_fwd(b3_s, b0_s, b1_s, b2_s), mix_row_fwd(b2_s, b3_s, b0_s, b1_s),
               mix_row_fwd(b1_s, b2_s, b3_s, b0_s), mix_row_fwd(b0_s, b1_s, b2_s, b3_s)};
`endif
   end

endmodule

// File: rtl/aes_mix_columns.sv
// Column-serial AES MixColumns round stage with valid/ready handshakes and final-round bypass.
// Define AES_MIX_INV_EN to add the in_inv port and InvMixColumns support.
module aes_mix_columns
   import aes_pkg::*;
#(
   parameter int NB = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [127:0]   in_block,
   input  logic           in_last,
`ifdef AES_MIX_INV_EN
   input  logic           in_inv,
`endif
   output logic           out_valid,
   input  logic           out_ready,
   output logic [127:0]   out_block
);

   localparam int CW = (NB > 1) ? $clog2(NB) : 1;

   mix_state_e    state_r, state_s;
   logic [CW-1:0] col_cnt_r, col_cnt_s;
   logic [127:0]  work_r, work_s;
   logic [127:0]  out_block_r, out_block_s;
   logic          out_valid_r, out_valid_s;
   logic          last_r, last_s;
   logic [31:0]   col_s, mixed_s;
`ifdef AES_MIX_INV_EN
   logic          inv_r, inv_s;
`endif

   assign in_ready  = (state_r == IDLE) | ((state_r == DONE) & out_ready);
   assign out_valid = out_valid_r;
   assign out_block = out_block_r;
   assign col_s     = get_col(work_r, 32'(col_cnt_r));

   aes_mix_col u_mix_col (
      .col   (col_s),
`ifdef AES_MIX_INV_EN
      .inv   (inv_r),
`endif
      .mixed (mixed_s)
   );

   // Next-state, working-column update and output register loads.
   always_comb begin
      state_s     = state_r;
      col_cnt_s   = col_cnt_r;
      work_s      = work_r;
      out_block_s = out_block_r;
      out_valid_s = out_valid_r;
      last_s      = last_r;
`ifdef AES_MIX_INV_EN
      inv_s       = inv_r;
`endif
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               work_s    = in_block;
               last_s    = in_last;
`ifdef AES_MIX_INV_EN
               inv_s     = in_inv;
`endif
               col_cnt_s = {CW{1'b0}};
               state_s   = BUSY;
            end else begin
               state_s   = IDLE;
            end
         end
         BUSY: begin
            // A bypass block spends one cycle here so both paths share the DONE entry.
            if (last_r) begin
               out_block_s = work_r;
               out_valid_s = 1'b1;
               state_s     = DONE;
            end else begin
               work_s = set_col(work_r, 32'(col_cnt_r), mixed_s);
               if (col_cnt_r == CW'(NB - 1)) begin
                  col_cnt_s   = {CW{1'b0}};
                  out_block_s = work_s;
                  out_valid_s = 1'b1;
                  state_s     = DONE;
               end else begin
                  col_cnt_s   = col_cnt_r + CW'(1'b1);
               end
            end
         end
         DONE: begin
            if (out_ready) begin
               out_valid_s = 1'b0;
               if (in_valid) begin
                  work_s    = in_block;
                  last_s    = in_last;
`ifdef AES_MIX_INV_EN
                  inv_s     = in_inv;
`endif
                  col_cnt_s = {CW{1'b0}};
                  state_s   = BUSY;
               end else begin
                  state_s   = IDLE;
               end
            end else begin
               state_s = DONE;
            end
         end
         default: begin
            state_s     = IDLE;
            col_cnt_s   = {CW{1'b0}};
            out_valid_s = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset discards any in-flight block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         col_cnt_r   <= {CW{1'b0}};
         work_r      <= 128'h0;
         out_block_r <= 128'h0;
         out_valid_r <= 1'b0;
         last_r      <= 1'b0;
`ifdef AES_MIX_INV_EN
         inv_r       <= 1'b0;
`endif
      end else begin
         state_r     <= state_s;
         col_cnt_r   <= col_cnt_s;
         work_r      <= work_s;
         out_block_r <= out_block_s;
         out_valid_r <= out_valid_s;
         last_r      <= last_s;
`ifdef AES_MIX_INV_EN
         inv_r       <= inv_s;
`endif
      end
   end

endmodule
